ram_data_chk: RTL
=================

# ram_data_chk

Receive-side checker for the 8-bit incrementing test pattern (0..255, wrap to 0) used on the PCIe scan RAM path. It sits on the H2C/readback side and consumes the byte stream after it has crossed RAM and DMA. It locks onto the stream and verifies that every valid byte equals the previous one plus 1 (mod 256). It reports lock, a sticky error flag, a saturating error count and a byte count to the user register block.

## Interface
Parameters:
- CNT_W, 32, width of byte_cnt
- ERR_W, 16, width of err_cnt
- RESYNC_TH, 4, consecutive mismatches that drop lock (range 1..15)

Ports:
- clk_50m  in  1  block clock, 50 MHz
- usr_rst_n  in  1  reset, asynchronous, active-low
- usr_h2c0r_run_i  in  1  level enable; checker is armed while high
- s0_axis_h2c_rst_i  in  1  synchronous clear of all state and outputs; dominates every other input
- data_valid  in  1  qualifies data_rx this cycle
- data_rx  in  8  received pattern byte
- chk_lock  out  1  high while in LOCK
- chk_err  out  1  sticky; set on first mismatch in LOCK
- err_cnt  out  ERR_W  mismatch count, saturates at all-ones
- byte_cnt  out  CNT_W  valid bytes accepted while armed, wraps
- err_exp  out  8  expected byte at first error (capture feature)
- err_got  out  8  received byte at first error (capture feature)

## Operation
- Reset and clear values: all outputs 0, state IDLE, expected register 0, mismatch run counter 0.
- FSM states:
  - IDLE: data_valid ignored. Go to SEEK when usr_h2c0r_run_i=1.
  - SEEK: first valid byte B is accepted unchecked; expected := B+1; go to LOCK.
  - LOCK: on each valid byte, compare with expected, then expected := expected+1 regardless of outcome. A single corrupted byte therefore counts as exactly one error.
- Mismatch in LOCK: err_cnt+1 (saturating), chk_err:=1, run counter+1. A match clears the run counter.
- When the run counter reaches RESYNC_TH, go to SEEK and clear the run counter. The byte that triggered the drop is still counted in err_cnt.
- usr_h2c0r_run_i=0 in SEEK or LOCK → IDLE on the next edge. Counters, chk_err and captures hold. chk_lock clears.
- Wrap: expected 255 → 0. A received 0 after 255 is a match.
- byte_cnt increments on every valid byte in SEEK or LOCK, and wraps mod 2^CNT_W.
- s0_axis_h2c_rst_i=1 in the same cycle as data_valid: the clear wins and the byte is dropped.
- Asynchronous reset mid-stream: immediate return to reset values. The next run begins in SEEK.

## Timing
- All outputs are registered.
- Verdict latency is 1 cycle: chk_err, err_cnt and byte_cnt reflect the byte sampled at edge N from edge N onward.
- chk_lock rises on the edge that samples the first valid byte in SEEK.
- IDLE→SEEK takes 1 cycle after run rises, so a valid byte coincident with the run rising edge is ignored.
- Throughput is 1 byte per cycle. No backpressure; the block is always ready.

## Configuration
- RAM_DATA_CHK_CAPTURE_EN defined: on the first mismatch after reset or clear, latch err_exp/err_got. Later mismatches do not overwrite them.
- RAM_DATA_CHK_CAPTURE_EN undefined: err_exp and err_got are tied to 0 and no capture registers are built. All other behaviour is identical.

## Structure
- Shared package ram_chk_pkg holds:
  - the state enum (IDLE, SEEK, LOCK)
  - the default CNT_W, ERR_W and RESYNC_TH constants
  - the pattern step constant (8'd1), shared with the generator side
- One sub-module, ram_chk_err_cap: first-error capture registers, instantiated only under RAM_DATA_CHK_CAPTURE_EN.
- FSM, compare and counters stay in the top module.

## Test plan
- Run=1, feed 0..255,0..9 with valid every cycle → chk_lock=1 from the 2nd cycle, err_cnt=0, chk_err=0, byte_cnt=266.
- Locked stream 10,11,99,13,14 → err_cnt=1, chk_err=1, lock held. With capture enabled: err_exp=12, err_got=99.
- In LOCK, 4 consecutive wrong bytes (RESYNC_TH=4), then 50,51,52 → err_cnt=4, state SEEK after the 4th. Relock on 50; no further errors.
- s0_axis_h2c_rst_i pulsed together with valid while err_cnt=3 → next cycle all outputs 0, state IDLE (run still high → SEEK the following cycle), byte dropped.
- Force err_cnt to near all-ones (ERR_W=4, 20 mismatches spaced by matches so lock is held) → err_cnt=15 and holds.
- Run dropped mid-stream, then re-raised with an unrelated start byte 200 → no error from the discontinuity. Counters continue from their held values.

Source files
------------

// File: rtl/ram_chk_pkg.sv
// ram_chk_pkg
// Shared definitions for the incrementing-pattern RAM checker and its
// generator counterpart: checker state encoding, default sizing constants
// and the pattern step between consecutive bytes.
package ram_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int CNT_W_DEF     = 32;
    localparam int ERR_W_DEF     = 16;
    localparam int RESYNC_TH_DEF = 4;

    // Width of the consecutive-mismatch run counter (threshold is 1..15).
    localparam int RUN_W = 4;

    // Difference between consecutive pattern bytes; the generator uses it too.
    localparam logic [7:0] PAT_STEP = 8'd1;

endpackage

// File: rtl/ram_chk_err_cap.sv
// ram_chk_err_cap
// First-error capture: latches the expected and received byte of the first
// mismatch after reset or clear; later mismatches leave the capture alone.
// The module only exists when RAM_DATA_CHK_CAPTURE_EN is defined, matching
// the only place it is instantiated.
// Ports:
//   clk      in   block clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear (dominates)
//   hit      in   mismatch seen this cycle
//   exp_in   in   expected byte for this cycle
//   got_in   in   received byte for this cycle
//   err_exp  out  captured expected byte
//   err_got  out  captured received byte
`ifdef RAM_DATA_CHK_CAPTURE_EN
module ram_chk_err_cap (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       hit,
    input  logic [7:0] exp_in,
    input  logic [7:0] got_in,
    output logic [7:0] err_exp,
    output logic [7:0] err_got
);

    logic captured;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured <= 1'b0;
            err_exp  <= 8'd0;
            err_got  <= 8'd0;
        end else if (clr) begin
            captured <= 1'b0;
            err_exp  <= 8'd0;
            err_got  <= 8'd0;
        end else if (hit && !captured) begin
            captured <= 1'b1;
            err_exp  <= exp_in;
            err_got  <= got_in;
        end
    end

endmodule
`endif

// File: rtl/ram_data_chk.sv
// ram_data_chk
// Receive-side checker for the 8-bit incrementing pattern (0..255, wrap).
// Locks onto the stream on the first valid byte, then checks each valid byte
// against previous+1. Reports lock, sticky error, saturating error count and
// a wrapping byte count. Optional first-error capture is built only when the
// macro RAM_DATA_CHK_CAPTURE_EN is defined; otherwise err_exp/err_got are 0.
//
// Handshake: data_valid qualifies data_rx for exactly one cycle; there is no
// ready signal, the block accepts a byte on every cycle data_valid is high.
//
// Ports:
//   clk_50m            in   block clock
//   usr_rst_n          in   asynchronous active-low reset
//   usr_h2c0r_run_i    in   level enable, checker armed while high
//   s0_axis_h2c_rst_i  in   synchronous clear of all state, dominates
//   data_valid         in   qualifies data_rx
//   data_rx            in   received pattern byte
//   chk_lock           out  high while locked
//   chk_err            out  sticky mismatch flag
//   err_cnt            out  saturating mismatch count
//   byte_cnt           out  wrapping count of accepted bytes
//   err_exp            out  expected byte at first error (capture build)
//   err_got            out  received byte at first error (capture build)
//   dbg_state          out  current FSM state, for debug/observation
module ram_data_chk
    import ram_chk_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ERR_W     = ERR_W_DEF,
    parameter int RESYNC_TH = RESYNC_TH_DEF
) (
    input  logic             clk_50m,
    input  logic             usr_rst_n,
    input  logic             usr_h2c0r_run_i,
    input  logic             s0_axis_h2c_rst_i,
    input  logic             data_valid,
    input  logic [7:0]       data_rx,
    output logic             chk_lock,
    output logic             chk_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [7:0]       err_exp,
    output logic [7:0]       err_got,
    output state_t           dbg_state
);

    localparam logic [RUN_W-1:0] RUN_TH  = RESYNC_TH[RUN_W-1:0];
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [7:0]       exp_byte;
    logic [RUN_W-1:0] run_cnt;
    logic             take;
    logic             mismatch;

    // A byte is consumed only when armed, not being cleared, and valid.
    assign take     = usr_h2c0r_run_i && !s0_axis_h2c_rst_i && data_valid;
    assign mismatch = take && (state == LOCK) && (data_rx != exp_byte);

    assign dbg_state = state;

    always_ff @(posedge clk_50m or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state    <= IDLE;
            exp_byte <= 8'd0;
            run_cnt  <= '0;
            chk_lock <= 1'b0;
            chk_err  <= 1'b0;
            err_cnt  <= '0;
            byte_cnt <= '0;
        end else if (s0_axis_h2c_rst_i) begin
            state    <= IDLE;
            exp_byte <= 8'd0;
            run_cnt  <= '0;
            chk_lock <= 1'b0;
            chk_err  <= 1'b0;
            err_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    chk_lock <= 1'b0;
                    if (usr_h2c0r_run_i) begin
                        state <= SEEK;
                    end
                end

                SEEK: begin
                    if (!usr_h2c0r_run_i) begin
                        state    <= IDLE;
                        chk_lock <= 1'b0;
                    end else if (take) begin
                        // First byte is trusted and defines the sequence.
                        byte_cnt <= byte_cnt + CNT_ONE;
                        exp_byte <= data_rx + PAT_STEP;
                        state    <= LOCK;
                        chk_lock <= 1'b1;
                    end
                end

                LOCK: begin
                    if (!usr_h2c0r_run_i) begin
                        state    <= IDLE;
                        chk_lock <= 1'b0;
                    end else if (take) begin
                        byte_cnt <= byte_cnt + CNT_ONE;
                        // Advance regardless of outcome so one bad byte is one error.
                        exp_byte <= exp_byte + PAT_STEP;
                        if (mismatch) begin
                            chk_err <= 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + ERR_ONE;
                            end
                            if (run_cnt + RUN_ONE >= RUN_TH) begin
                                state    <= SEEK;
                                chk_lock <= 1'b0;
                                run_cnt  <= '0;
                            end else begin
                                run_cnt <= run_cnt + RUN_ONE;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    chk_lock <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_DATA_CHK_CAPTURE_EN
    ram_chk_err_cap u_err_cap (
        .clk     (clk_50m),
        .rst_n   (usr_rst_n),
        .clr     (s0_axis_h2c_rst_i),
        .hit     (mismatch),
        .exp_in  (exp_byte),
        .got_in  (data_rx),
        .err_exp (err_exp),
        .err_got (err_got)
    );
`else
    assign err_exp = 8'd0;
    assign err_got = 8'd0;
`endif

endmodule
